// File: rtl/sdram_burst_prefetch.sv
// Burst prefetch from the SDRAM controller read port into a
// two-bank ping-pong buffer drained by the QSPI read side.
module sdram_burst_prefetch #(
  parameter int DW = 16,
  parameter int AW = 24,
  parameter int BL = 8,
  parameter int ADDR_SHIFT = 1,
  localparam int BW = $clog2(BL)
) (
  input  logic          sdram_clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          busy,
  output logic [1:0]    buf_valid,
  input  logic [1:0]    buf_release,
  output logic          done,
  output logic          done_bank,
  input  logic          ram_ren,
  input  logic          ram_rbank,
  input  logic [BW-1:0] ram_raddr,
  output logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] rd_addr,
  output logic          rd_avalid,
  input  logic          rd_aready,
  input  logic [DW-1:0] rd_data,
  input  logic          rd_valid,
  output logic          rd_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          wr_bank;
  logic [BW-1:0] beat_cnt;
  logic          accept;
  logic          beat;
  logic          last;
  logic [1:0]    bv_set;
  logic [1:0]    bv_nx;
  logic [DW-1:0] mem [0:2*BL-1];

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rd_avalid = 1'b0;
    rd_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !buf_valid[wr_bank];
        if (req_valid && !buf_valid[wr_bank])
          state_nx = ADDR;
      end
      ADDR: begin
        rd_avalid = 1'b1;
        if (rd_aready)
          state_nx = DATA;
      end
      DATA: begin
        rd_ready = 1'b1;
        if (rd_valid && beat_cnt == BW'(BL-1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign beat   = rd_ready && rd_valid;
  assign last   = beat && (beat_cnt == BW'(BL-1));
  assign busy   = (state != IDLE);

  // A bank being filled is never valid, so set wins trivially
  assign bv_set = {last & wr_bank, last & ~wr_bank};
  assign bv_nx  = bv_set | (buf_valid & ~buf_release);

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_bank   <= 1'b0;
      beat_cnt  <= '0;
      buf_valid <= 2'b00;
      rd_addr   <= '0;
      done      <= 1'b0;
      done_bank <= 1'b0;
    end else begin
      state     <= state_nx;
      buf_valid <= bv_nx;
      done      <= last;
      if (accept)
        rd_addr <= req_addr >> ADDR_SHIFT;
      if (beat)
        beat_cnt <= beat_cnt + 1'b1;
      if (last) begin
        done_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (beat)
      mem[{wr_bank, beat_cnt}] <= rd_data;
  end

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n)
      ram_rdata <= '0;
    else if (ram_ren)
      ram_rdata <= mem[{ram_rbank, ram_raddr}];
  end

endmodule

// File: tb/tb_sdram_burst_prefetch.sv
// Scoreboard bench for sdram_burst_prefetch: default build
// plus a DW=32/AW=32/BL=4/ADDR_SHIFT=2 build.
module tb_sdram_burst_prefetch;

  logic        sdram_clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        busy;
  logic [1:0]  buf_valid;
  logic [1:0]  buf_release;
  logic        done;
  logic        done_bank;
  logic        ram_ren;
  logic        ram_rbank;
  logic [2:0]  ram_raddr;
  logic [15:0] ram_rdata;
  logic [23:0] rd_addr;
  logic        rd_avalid;
  logic        rd_aready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  logic        p_req_valid;
  logic        p_req_ready;
  logic [31:0] p_req_addr;
  logic        p_busy;
  logic [1:0]  p_buf_valid;
  logic [1:0]  p_buf_release;
  logic        p_done;
  logic        p_done_bank;
  logic        p_ram_ren;
  logic        p_ram_rbank;
  logic [1:0]  p_ram_raddr;
  logic [31:0] p_ram_rdata;
  logic [31:0] p_rd_addr;
  logic        p_rd_avalid;
  logic        p_rd_aready;
  logic [31:0] p_rd_data;
  logic        p_rd_valid;
  logic        p_rd_ready;

  int          n_chk;
  int          n_err;
  int          n_done;
  bit          wb;
  logic [1:0]  exp_bv;
  logic [15:0] mdl [2][8];
  logic [63:0] rq[$];
  bit          done_q[$];

  sdram_burst_prefetch dut (
    .sdram_clk   (sdram_clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .busy        (busy),
    .buf_valid   (buf_valid),
    .buf_release (buf_release),
    .done        (done),
    .done_bank   (done_bank),
    .ram_ren     (ram_ren),
    .ram_rbank   (ram_rbank),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata),
    .rd_addr     (rd_addr),
    .rd_avalid   (rd_avalid),
    .rd_aready   (rd_aready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready)
  );

  sdram_burst_prefetch #(
    .DW(32), .AW(32), .BL(4), .ADDR_SHIFT(2)
  ) dut_p (
    .sdram_clk   (sdram_clk),
    .rst_n       (rst_n),
    .req_valid   (p_req_valid),
    .req_ready   (p_req_ready),
    .req_addr    (p_req_addr),
    .busy        (p_busy),
    .buf_valid   (p_buf_valid),
    .buf_release (p_buf_release),
    .done        (p_done),
    .done_bank   (p_done_bank),
    .ram_ren     (p_ram_ren),
    .ram_rbank   (p_ram_rbank),
    .ram_raddr   (p_ram_raddr),
    .ram_rdata   (p_ram_rdata),
    .rd_addr     (p_rd_addr),
    .rd_avalid   (p_rd_avalid),
    .rd_aready   (p_rd_aready),
    .rd_data     (p_rd_data),
    .rd_valid    (p_rd_valid),
    .rd_ready    (p_rd_ready)
  );

  initial begin
    sdram_clk = 1'b0;
    forever #5 sdram_clk = ~sdram_clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge sdram_clk) begin
    if (rst_n && done) begin
      n_done++;
      if (done_q.size() == 0)
        chk("done_spurious", 1, 0);
      else
        chk("done_bank", done_bank, done_q.pop_front());
    end
  end

  task automatic burst(input logic [23:0] addr,
                       input logic [15:0] base,
                       input int dly,
                       input int gap,
                       input bit spur,
                       input int nb);
    logic [23:0] ea;
    ea = addr >> 1;
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge sdram_clk);
    req_valid = 1'b0;
    req_addr  = '0;
    chk("rd_addr", rd_addr, ea);
    chk("avalid", rd_avalid, 1);
    chk("busy", busy, 1);
    chk("ready_in_addr", rd_ready, 0);
    for (int k = 0; k < dly; k++) begin
      rd_aready = 1'b0;
      rd_valid  = spur;
      rd_data   = 16'hdead;
      @(negedge sdram_clk);
      chk("avalid_hold", rd_avalid, 1);
      chk("rd_addr_hold", rd_addr, ea);
      chk("ready_stall", rd_ready, 0);
    end
    rd_valid  = 1'b0;
    rd_aready = 1'b1;
    @(negedge sdram_clk);
    rd_aready = 1'b0;
    chk("avalid_drop", rd_avalid, 0);
    chk("rd_ready", rd_ready, 1);
    for (int i = 0; i < nb; i++) begin
      if (gap > 0 && i > 0) begin
        rd_valid = 1'b0;
        rd_data  = 16'hbad0;
        repeat ($urandom_range(1, gap))
          @(negedge sdram_clk);
        chk("rd_addr_data", rd_addr, ea);
      end
      rd_valid  = 1'b1;
      rd_data   = base + 16'(i);
      mdl[wb][i] = base + 16'(i);
      if (i == 7)
        done_q.push_back(wb);
      @(negedge sdram_clk);
    end
    rd_valid = 1'b0;
    if (nb == 8) begin
      exp_bv[wb] = 1'b1;
      chk("buf_valid_set", buf_valid, exp_bv);
      chk("idle_after", busy, 0);
      wb = ~wb;
    end
  endtask

  task automatic rd_chk(input bit b);
    for (int i = 0; i < 8; i++) begin
      ram_ren   = 1'b1;
      ram_rbank = b;
      ram_raddr = 3'(i);
      rq.push_back(64'(mdl[b][i]));
      @(negedge sdram_clk);
      chk("ram_rdata", ram_rdata, rq.pop_front());
    end
    ram_ren   = 1'b0;
    ram_raddr = 3'd0;
    @(negedge sdram_clk);
    chk("rdata_hold", ram_rdata, mdl[b][7]);
  endtask

  task automatic rel(input logic [1:0] m);
    buf_release = m;
    @(negedge sdram_clk);
    buf_release = 2'b00;
    exp_bv = exp_bv & ~m;
    chk("buf_valid_rel", buf_valid, exp_bv);
  endtask

  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_buf_valid", buf_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_done_bank", done_bank, 0);
    chk("rst_rdata", ram_rdata, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_avalid", rd_avalid, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_req_ready", req_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int d0;
    n_chk = 0; n_err = 0; n_done = 0;
    wb = 1'b0; exp_bv = 2'b00;
    rst_n = 1'b0;
    req_valid = 0; req_addr = '0;
    buf_release = 2'b00;
    ram_ren = 0; ram_rbank = 0; ram_raddr = '0;
    rd_aready = 0; rd_data = '0; rd_valid = 0;
    p_req_valid = 0; p_req_addr = '0;
    p_buf_release = 2'b00;
    p_ram_ren = 0; p_ram_rbank = 0; p_ram_raddr = '0;
    p_rd_aready = 0; p_rd_data = '0; p_rd_valid = 0;
    repeat (2) @(negedge sdram_clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge sdram_clk);

    burst(24'h000010, 16'h1000, 0, 0, 0, 8);
    rd_chk(0);
    rel(2'b01);

    d0 = n_done;
    burst(24'h000200, 16'h2000, 5, 3, 0, 8);
    rd_chk(1);
    chk("done_once", n_done, d0 + 1);
    rel(2'b10);

    burst(24'h000400, 16'h3000, 0, 0, 0, 8);
    burst(24'h000800, 16'h4000, 1, 1, 0, 8);
    chk("both_valid", buf_valid, 2'b11);
    req_valid = 1'b1;
    req_addr  = 24'h000c00;
    repeat (3) begin
      @(negedge sdram_clk);
      chk("full_req_ready", req_ready, 0);
      chk("full_busy", busy, 0);
    end
    req_valid = 1'b0;
    rel(2'b01);
    chk("req_ready_rel", req_ready, 1);
    burst(24'h000c00, 16'h5000, 0, 0, 0, 8);
    rd_chk(0);
    rd_chk(1);
    rel(2'b11);

    rd_valid = 1'b1;
    rd_data  = 16'hbeef;
    @(negedge sdram_clk);
    rd_valid = 1'b0;
    chk("spur_idle_ready", rd_ready, 0);
    chk("spur_idle_busy", busy, 0);
    burst(24'h001000, 16'h6000, 2, 0, 1, 8);
    rd_chk(1);
    rd_chk(0);
    rel(2'b01);

    burst(24'h002000, 16'h7000, 0, 0, 0, 3);
    rst_n = 1'b0;
    #1;
    exp_bv = 2'b00;
    wb = 1'b0;
    chk_reset();
    @(negedge sdram_clk);
    rst_n = 1'b1;
    @(negedge sdram_clk);
    burst(24'h002000, 16'h8000, 0, 0, 0, 8);
    rd_chk(0);
    rel(2'b01);

    chk("p_req_ready", p_req_ready, 1);
    p_req_valid = 1'b1;
    p_req_addr  = 32'h00000100;
    @(negedge sdram_clk);
    p_req_valid = 1'b0;
    chk("p_rd_addr", p_rd_addr, 32'h00000040);
    chk("p_avalid", p_rd_avalid, 1);
    p_rd_aready = 1'b1;
    @(negedge sdram_clk);
    p_rd_aready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p_rd_valid = 1'b1;
      p_rd_data  = 32'ha5000000 + 32'(i);
      @(negedge sdram_clk);
      if (i < 3)
        chk("p_no_done", p_done, 0);
    end
    p_rd_valid = 1'b0;
    chk("p_done", p_done, 1);
    chk("p_done_bank", p_done_bank, 0);
    chk("p_buf_valid", p_buf_valid, 2'b01);
    for (int i = 0; i < 4; i++) begin
      p_ram_ren   = 1'b1;
      p_ram_raddr = 2'(i);
      rq.push_back(64'(32'ha5000000 + 32'(i)));
      @(negedge sdram_clk);
      chk("p_ram_rdata", p_ram_rdata, rq.pop_front());
      if (i == 0)
        chk("p_done_pulse", p_done, 0);
    end
    p_ram_ren = 1'b0;

    chk("done_q_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_burst_prefetch.md
Name: sdram_burst_prefetch

Overview:
- Single-clock, parametrised successor of the QSPI-to-SDRAM read path.
- Accepts byte-addressed read requests and issues one address handshake per request on the SDRAM controller read port. Each request fetches a BL-beat burst.
- Bursts land in a two-bank ping-pong buffer, so the next prefetch can run while the consumer drains the previous bank.
- Sits between the QSPI slave logic (after its CDC) and the SDRAM controller, all on sdram_clk.

Parameters:
- DW, 16: data width of SDRAM beats and buffer words.
- AW, 24: address width of req_addr and rd_addr.
- BL, 8: beats per burst. Must be a power of 2 with 2 <= BL <= 256. BW = log2(BL).
- ADDR_SHIFT, 1: right shift from byte address to controller word address. Vacated MSBs are zero-filled.

Ports:
- sdram_clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  read request.
- req_ready  out  1  request can be accepted.
- req_addr  in  AW  byte address of the burst start.
- busy  out  1  FSM not in IDLE.
- buf_valid  out  2  per-bank "burst complete, data readable" flag.
- buf_release  in  2  per-bank pulse from the consumer; clears buf_valid[b].
- done  out  1  one-cycle pulse when a burst completes.
- done_bank  out  1  bank index of that completed burst; valid while done=1.
- ram_ren  in  1  buffer read enable.
- ram_rbank  in  1  buffer bank to read.
- ram_raddr  in  BW  word index within the bank.
- ram_rdata  out  DW  registered read data.
- rd_addr  out  AW  controller word address.
- rd_avalid  out  1  address valid.
- rd_aready  in  1  controller accepts the address.
- rd_data  in  DW  controller read beat.
- rd_valid  in  1  beat valid.
- rd_ready  out  1  block accepts beats.

Behaviour:
- Reset values:
  - FSM=IDLE, wr_bank=0, beat_cnt=0, buf_valid=2'b00.
  - rd_addr=0, rd_avalid=0, rd_ready=0, done=0, done_bank=0, ram_rdata=0, busy=0.
  - Buffer contents are not reset.
- req_ready = (state==IDLE) && !buf_valid[wr_bank]. This is combinational. Accept = req_valid && req_ready.
- On accept: rd_addr <= req_addr >> ADDR_SHIFT, captured in that cycle; state -> ADDR.
- rd_addr holds its value until the next accept.
- FSM states:
  - IDLE: leave only on accept, going to ADDR.
  - ADDR: rd_avalid=1. On rd_avalid && rd_aready -> DATA. Otherwise stay in ADDR with rd_addr stable.
  - DATA: rd_ready=1. On each rd_valid beat:
    - write rd_data to buffer[wr_bank][beat_cnt];
    - beat_cnt++ (BW bits).
    - On the beat with beat_cnt==BL-1: beat_cnt <= 0, buf_valid[wr_bank] <= 1, done <= 1, done_bank <= wr_bank, wr_bank toggles, state -> IDLE.
- rd_avalid and rd_ready are pure decodes of state. rd_valid outside DATA is ignored and nothing is written.
- Back-to-back requests:
  - A new request can be accepted in the cycle after the last beat if the other bank is free. The minimum request-to-request interval is 1 + 1 + BL cycles, assuming aready and valid are immediate.
  - If both banks are valid, req_ready=0 until a release arrives.
- Release:
  - buf_release[b] clears buf_valid[b] on the next edge.
  - Release of a bank that is already clear has no effect.
  - A release and a set cannot target the same bank in the same cycle, because a bank being filled is by construction not valid. The set wins if it ever happens.
  - Both bits of buf_release may be asserted together.
- Buffer read:
  - ram_rdata <= buffer[ram_rbank][ram_raddr] on ram_ren. Latency is 1 cycle.
  - ram_rdata holds its value when ram_ren=0.
  - Read and write of the same location in the same cycle returns the old data.
  - Reads of a non-valid bank are legal but return stale contents.
- busy = (state!=IDLE).
- Reset asserted mid-burst:
  - Returns immediately to reset values and the burst is abandoned.
  - The controller-side consequences of an abandoned burst are owned by the system reset.

Test Plan:
- Single request, BL=8: req_addr=24'h000010 accepted with aready immediate, then 8 beats 16'h1000..16'h1007. Expect:
  - rd_addr=24'h000008;
  - rd_avalid high for 1 cycle;
  - done with done_bank=0 the cycle after beat 8, and buf_valid=2'b01;
  - reading bank 0 at addresses 0..7 returns 1000..1007 one cycle after each ram_ren.
- Stalls: rd_aready held low for 5 cycles, then 8 beats with rd_valid gaps of 1–3 cycles. Expect:
  - rd_addr stable throughout;
  - beat_cnt advances only on valid beats;
  - exactly 8 words stored;
  - done pulses exactly once.
- Ping-pong full: 2 requests with no release. Expect:
  - buf_valid=2'b11 and req_ready=0 while req_valid is held;
  - after pulsing buf_release=2'b01, req_ready=1 on the next cycle;
  - the third burst lands in bank 0 with done_bank=0.
- Spurious data: rd_valid pulsed while in IDLE and in ADDR. Expect:
  - rd_ready=0;
  - buffer contents and beat_cnt unchanged.
- Reset mid-burst: assert rst_n=0 after beat 3 of 8. Expect:
  - all outputs return to reset values asynchronously;
  - after release of reset, a fresh request fills bank 0 from index 0.
- Parameter sweep: DW=32, AW=32, BL=4, ADDR_SHIFT=2, with req_addr=32'h00000100. Expect:
  - rd_addr=32'h00000040;
  - a 4-beat burst completes;
  - ram_raddr is 2 bits wide.
